// File: rtl/pulse_count_arbiter_pkg.sv
// Shared types and defaults for the pulse-count arbiter: FSM state encoding,
// default sizing and the index-width helper.
package pulse_count_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam int N_DEF     = 4;
  localparam int TMO_DEF   = 200;
  localparam int TMO_W_DEF = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_w(N_DEF);

endpackage

// File: rtl/pulse_count_arbiter_rr_pick.sv
// Combinational round-robin selector: first requesting index found searching
// upward from last+1, wrapping modulo N.
module pulse_count_arbiter_rr_pick
  import pulse_count_arbiter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last) + i) % N);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pulse_count_arbiter.sv
// Round-robin owner of a single 3-pulse counter: grants one requester, clears
// the counter, forwards only the winner's strobes and reports done or abort.
module pulse_count_arbiter
  import pulse_count_arbiter_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int TMO   = TMO_DEF,
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] ev,
  output logic [N-1:0] gnt,
  output logic [N-1:0] done,
  output logic [N-1:0] err,
  output logic         cnt_clr,
  output logic         cnt_x,
  input  logic         cnt_y
);

  localparam int IW = idx_w(N);

  state_t             state, state_nxt;
  logic [IW-1:0]      idx, last, pick_idx;
  logic               pick_vld;
  logic [TMO_W-1:0]   timer;
  logic [N-1:0]       sel;
  logic               tmo_hit;

  pulse_count_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .last  (last),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign tmo_hit = (timer == TMO_W'(TMO - 1));
  assign sel     = N'(1) << idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      last  <= IW'(N - 1);
      timer <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_vld)
        idx <= pick_idx;
      if (state == CLEAR)
        timer <= '0;
      else if (state == RUN)
        timer <= timer + 1'b1;
      if (state == DONE || state == ABORT)
        last <= idx;
    end
  end

  // Completion outranks a withdrawn request, which outranks the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = CLEAR;
      CLEAR:   state_nxt = RUN;
      RUN: begin
        if (cnt_y)         state_nxt = DONE;
        else if (!req[idx]) state_nxt = ABORT;
        else if (tmo_hit)  state_nxt = ABORT;
      end
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The counter is held cleared for the whole of reset, not just after it.
  always_comb begin
    gnt     = (state != IDLE)  ? sel : '0;
    done    = (state == DONE)  ? sel : '0;
    err     = (state == ABORT) ? sel : '0;
    cnt_clr = rst | (state == CLEAR) | (state == DONE) | (state == ABORT);
    cnt_x   = (state == RUN) & ev[idx] & ~cnt_y;
  end

endmodule

// File: tb/tb_pulse_count_arbiter.sv
// Bench for pulse_count_arbiter with a behavioural 4-state pulse counter
// attached to cnt_clr/cnt_x/cnt_y.
module tb_pulse_count_arbiter;

  localparam int N = 4;
  localparam int TMO = 200;
  localparam int TMO_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] ev = '0;
  logic [N-1:0] gnt, done, err;
  logic cnt_clr, cnt_x, cnt_y;

  logic [1:0] cst = 2'd0;
  logic prot_bad = 1'b0;
  logic wrap_bad = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pulse_count_arbiter #(.N(N), .TMO(TMO), .TMO_W(TMO_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ev      (ev),
    .gnt     (gnt),
    .done    (done),
    .err     (err),
    .cnt_clr (cnt_clr),
    .cnt_x   (cnt_x),
    .cnt_y   (cnt_y)
  );

  // Counter model: synchronous clear, x advances 0->1->2->3 and would wrap to 0.
  always @(posedge clk) begin
    if (cnt_clr)
      cst <= 2'd0;
    else if (cnt_x)
      cst <= cst + 2'd1;
  end
  assign cnt_y = (cst == 2'd3);

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(gnt) > 1 || $countones(done) > 1 || $countones(err) > 1 ||
          (|(done & err)) || (|((done | err) & ~gnt)))
        prot_bad <= 1'b1;
      if (cnt_x && cst == 2'd3)
        wrap_bad <= 1'b1;
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] ev;
    logic [3:0] gnt;
    logic [3:0] done;
    logic [3:0] err;
    logic       clr;
    logic       x;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    ev = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic xbad;
    logic [N-1:0] exp;

    // {req, ev, gnt, done, err, cnt_clr, cnt_x}
    tv[0] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tv[1] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0};
    tv[2] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tv[3] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tv[4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tv[5] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tv[6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1};
    tv[7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tv[8] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0};
    tv[9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    step();
    step();
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_clr", cnt_clr, 1);
    chk("rst_x", cnt_x, 0);
    rst = 1'b0;
    step();

    // Single requester, three pulses, ev held in the terminal cycle
    for (int i = 0; i < 10; i++) begin
      req = tv[i].req;
      ev = tv[i].ev;
      #1;
      chk($sformatf("v%0d_gnt", i), gnt, tv[i].gnt);
      chk($sformatf("v%0d_done", i), done, tv[i].done);
      chk($sformatf("v%0d_err", i), err, tv[i].err);
      chk($sformatf("v%0d_clr", i), cnt_clr, tv[i].clr);
      chk($sformatf("v%0d_x", i), cnt_x, tv[i].x);
      step();
    end

    // All requesting: rotation 0,1,2,3,0
    do_reset();
    req = 4'hF;
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      n = 0;
      while (gnt == 0 && n < 20) begin step(); n++; end
      chk($sformatf("rr%0d_gnt", g), gnt, exp);
      step();
      for (int p = 0; p < 3; p++) begin
        ev = gnt;
        step();
        ev = '0;
        step();
      end
      n = 0;
      while (done == 0 && n < 20) begin step(); n++; end
      chk($sformatf("rr%0d_done", g), done, exp);
      step();
      chk($sformatf("rr%0d_done_once", g), done, 0);
    end

    // Timeout with only foreign strobes
    do_reset();
    req = 4'b0100;
    step();
    chk("tmo_gnt", gnt, 4'b0100);
    step();
    n = 0;
    xbad = 1'b0;
    while (err == 0 && n < 300) begin
      ev = n[0] ? 4'b0000 : 4'b1011;
      #1;
      xbad = xbad | cnt_x;
      step();
      n++;
    end
    ev = '0;
    chk("tmo_cycles", n, TMO);
    chk("tmo_err", err, 4'b0100);
    chk("tmo_clr", cnt_clr, 1);
    chk("tmo_x_quiet", xbad, 0);
    req = '0;
    step();
    chk("tmo_gnt_off", gnt, 0);

    // Request withdrawn mid-run
    do_reset();
    req = 4'b0011;
    step();
    chk("wd_gnt0", gnt, 4'b0001);
    step();
    for (int p = 0; p < 2; p++) begin
      ev = 4'b0001;
      step();
      ev = '0;
      step();
    end
    chk("wd_cnt2", cst, 2);
    req = 4'b0010;
    step();
    chk("wd_err", err, 4'b0001);
    chk("wd_done", done, 0);
    chk("wd_clr", cnt_clr, 1);
    step();
    chk("wd_cnt_cleared", cst, 0);
    chk("wd_idle_gnt", gnt, 0);
    step();
    chk("wd_gnt1", gnt, 4'b0010);

    // Reset mid-run
    do_reset();
    req = 4'b0001;
    step();
    step();
    ev = 4'b0001;
    step();
    ev = '0;
    rst = 1'b1;
    req = '0;
    #1;
    chk("mr_gnt", gnt, 0);
    chk("mr_done", done, 0);
    chk("mr_err", err, 0);
    chk("mr_clr", cnt_clr, 1);
    step();
    chk("mr_cnt_cleared", cst, 0);
    rst = 1'b0;
    req = 4'b0010;
    step();
    chk("mr_gnt1", gnt, 4'b0010);
    req = '0;
    step();
    step();

    chk("protocol_onehot", prot_bad, 0);
    chk("counter_no_wrap", wrap_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_count_arbiter.md
# pulse_count_arbiter

Round-robin scheduler that shares one 4-state pulse-counting FSM (x strobe in, terminal flag y out, three x pulses from state 0 to terminal) among N requesters. It grants the counter to one requester at a time and clears it before use. It forwards only the winner's event strobe, waits for the terminal flag, and reports completion or abort. It sits between the requesting blocks and the single counter instance, and drives that counter's reset and x inputs.

## Interface
Parameters:
- N, 4: number of requesters (2..8).
- TMO, 200: max RUN cycles before abort (1..2^TMO_W-1).
- TMO_W, 8: timeout counter width.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  level request per requester; held until done/err.
- ev  in  N  per-requester event strobe (1-cycle pulses).
- gnt  out  N  one-hot grant; all-zero when idle.
- done  out  N  1-cycle completion pulse to the granted requester.
- err  out  N  1-cycle abort pulse (timeout or request withdrawn).
- cnt_clr  out  1  drives the counter's rst; 1-cycle clear pulse.
- cnt_x  out  1  drives the counter's x.
- cnt_y  in  1  counter terminal flag (high in terminal state).

## Operation
- States: IDLE, CLEAR, RUN, DONE, ABORT; registered state, encoding in package.
- IDLE: gnt=0. If req!=0, select winner by round-robin: first set bit searching upward from last+1 modulo N. Latch idx, set gnt[idx], go CLEAR.
- CLEAR: cnt_clr=1, cnt_x=0, timer←0, go RUN.
- RUN: cnt_x = ev[idx] & ~cnt_y (combinational). Events from non-granted requesters are dropped, not queued. Timer increments each cycle. Priority is cnt_y=1 → DONE; else req[idx]=0 → ABORT; else timer==TMO-1 → ABORT.
- DONE: done[idx]=1, cnt_clr=1, last←idx, go IDLE.
- ABORT: err[idx]=1, cnt_clr=1, last←idx, go IDLE.
- gnt[idx] is held from CLEAR through DONE/ABORT and is zero in IDLE.
- done and err are never both set. At most one bit of gnt/done/err is set.
- Reset: state=IDLE, gnt=0, done=0, err=0, cnt_clr=1 while rst is high (counter held in state 0), cnt_x=0, timer=0, last=N-1 (so requester 0 wins first).
- Reset mid-RUN: immediate abort with no done/err pulse. The counter is cleared through cnt_clr.

## Timing
- Grant latency: req sampled high in IDLE at edge k → gnt high after edge k (state CLEAR). cnt_clr is high for cycle k..k+1 and RUN starts after edge k+1.
- Counter sees cnt_x in the same cycle as ev (no extra stage). The third accepted pulse at edge m gives cnt_y=1 after m. DONE follows edge m+1, so done pulses in cycle m+1..m+2 and the next arbitration is possible at edge m+2.
- Minimum turnaround IDLE→IDLE is 4 cycles plus event time. A requester re-asserting immediately competes normally, with lowest priority.
- Simultaneous req from all: grants go 0,1,2,3,0… in rotation.
- An ev pulse coinciding with cnt_y=1 is masked and must not wrap the counter.
- A req drop in the same cycle as cnt_y=1 goes to DONE (completion wins).

## Structure
- Package pulse_count_arbiter_pkg: state enum (IDLE, CLEAR, RUN, DONE, ABORT), default N/TMO/TMO_W constants, clog2-based IDX_W.
- Sub-module rr_pick: combinational round-robin selector (req, last → idx, valid). It is the only natural split. The FSM, timer and output decode stay in the top.

## Test plan
- Reset, then req=0001, then three ev[0] pulses at 2-cycle spacing → gnt=0001 one cycle after req. cnt_clr pulses. cnt_x mirrors ev[0]. done=0001 two cycles after the 3rd pulse. gnt=0 next cycle.
- req=1111 held, each winner supplies 3 events → grant order 0,1,2,3,0. No gnt overlap. Exactly one done per grant.
- Granted req=0100 with ev=1011 pulses only → cnt_x stays 0. After TMO=200 RUN cycles: err=0100, cnt_clr=1, gnt=0.
- Grant 0, two events, then req[0] dropped → err=0001 next cycle, counter cleared. Next grant goes to requester 1 if requesting.
- After the 3rd event, ev[0] is held high during the cnt_y=1 cycle → cnt_x=0 and done=0001. The counter never returns to state 0 through x.
- rst asserted mid-RUN → gnt/done/err go 0 immediately and cnt_clr=1. After release, req=0010 → gnt=0010 (last reset to N-1).
